// File: rtl/hog_cell_hist_acc.sv
// HOG cell-histogram accumulator: clears a per-cell bin RAM, then accumulates raster-ordered
// (bin, magnitude) votes via a forwarded 3-stage RMW pipe. Define HOG_HIST_SAT_EN to clamp bins.
module hog_cell_hist_acc #(
  parameter int unsigned IMG_W = 136,
  parameter int unsigned IMG_H = 136,
  parameter int unsigned CELL  = 4,
  parameter int unsigned NBINS = 9,
  parameter int unsigned MAG_W = 16,
  parameter int unsigned ACC_W = 24,
  localparam int unsigned CX    = IMG_W / CELL,
  localparam int unsigned CY    = IMG_H / CELL,
  localparam int unsigned DEPTH = CX * CY * NBINS,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned BW    = $clog2(NBINS)
) (
  input  logic             aclk,
  input  logic             arest,
  input  logic             start,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [BW-1:0]    s_bin,
  input  logic [MAG_W-1:0] s_mag,
  input  logic             s_last,
  output logic             done,
  output logic             err,
  output logic             sat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [ACC_W-1:0] rd_data,
  output logic             rd_valid
);

  localparam int unsigned LOG_C = $clog2(CELL);
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CW    = $clog2(IMG_W + 1);
  localparam int unsigned RW    = $clog2(IMG_H + 1);
  localparam int unsigned PW    = $clog2(NPIX + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t state, nxt;
  logic busy_d, ready_d, done_d;
  logic [AW-1:0] clr_cnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] pix_cnt;
  logic accept, final_pix, bin_ok, start_acc;
  logic [AW-1:0] s0_addr;
  logic hit1, hit2;

  logic             s1_vld, s1_fwd;
  logic [AW-1:0]    s1_addr;
  logic [MAG_W-1:0] s1_mag;
  logic [ACC_W-1:0] s1_fval, s1_old, s1_sum;
  logic             s2_vld;
  logic [AW-1:0]    s2_addr;
  logic [ACC_W-1:0] s2_sum;
  logic [ACC_W-1:0] ram_q;
  logic [ACC_W-1:0] mem [DEPTH];

  // Vote decode; S0 address comes straight from the raster counters
  always_comb begin
    accept    = (state == S_ACCUM) && s_valid;
    final_pix = (32'(pix_cnt) == NPIX - 1);
    bin_ok    = (32'(s_bin) < NBINS);
    start_acc = ((state == S_IDLE) || (state == S_DONE)) && start;
    s0_addr   = AW'((32'(row >> LOG_C) * CX + 32'(col >> LOG_C)) * NBINS + 32'(s_bin));
    hit1      = s1_vld && (s1_addr == s0_addr);
    hit2      = s2_vld && (s2_addr == s0_addr);
  end

  always_ff @(posedge aclk or posedge arest) begin
    if (arest) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) nxt = S_CLEAR;
      S_CLEAR:        if (32'(clr_cnt) == DEPTH - 1) nxt = S_ACCUM;
      S_ACCUM:        if (accept && (s_last || final_pix)) nxt = S_DRAIN;
      S_DRAIN:        if (!s1_vld) nxt = S_DONE;
      default:        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (nxt == S_CLEAR) || (nxt == S_ACCUM) || (nxt == S_DRAIN);
    ready_d = (nxt == S_ACCUM);
    done_d  = (nxt == S_DONE);
  end

  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      busy    <= 1'b0;
      s_ready <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy    <= busy_d;
      s_ready <= ready_d;
      done    <= done_d;
    end
  end

  // Clear sweep, raster counters and frame-length / bin-range error
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      clr_cnt <= '0;
      col     <= '0;
      row     <= '0;
      pix_cnt <= '0;
      err     <= 1'b0;
    end else if (start_acc) begin
      clr_cnt <= '0;
      col     <= '0;
      row     <= '0;
      pix_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state == S_CLEAR) clr_cnt <= clr_cnt + AW'(1);
      if (accept) begin
        pix_cnt <= pix_cnt + PW'(1);
        if (32'(col) == IMG_W - 1) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if ((s_last && !final_pix) || (final_pix && !s_last) || !bin_ok) err <= 1'b1;
      end
    end
  end

  // RMW pipe: S1 takes the forwarded in-flight sum when S0 hit a younger write
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      s1_vld  <= 1'b0;
      s1_fwd  <= 1'b0;
      s1_addr <= '0;
      s1_mag  <= '0;
      s1_fval <= '0;
      s2_vld  <= 1'b0;
      s2_addr <= '0;
      s2_sum  <= '0;
    end else begin
      s1_vld  <= accept && bin_ok;
      s1_fwd  <= hit1 || hit2;
      s1_addr <= s0_addr;
      s1_mag  <= s_mag;
      s1_fval <= hit1 ? s1_sum : s2_sum;
      s2_vld  <= s1_vld;
      s2_addr <= s1_addr;
      s2_sum  <= s1_sum;
    end
  end

  always_comb s1_old = s1_fwd ? s1_fval : ram_q;

`ifdef HOG_HIST_SAT_EN
  localparam int unsigned SW = ACC_W + 1;
  logic [ACC_W:0] sum_w;
  logic           s1_clamp;

  always_comb begin
    sum_w    = {1'b0, s1_old} + SW'(s1_mag);
    s1_clamp = sum_w[ACC_W];
    s1_sum   = s1_clamp ? '1 : sum_w[ACC_W-1:0];
  end

  // Raised as the clamped sum enters S2, i.e. during its write cycle
  always_ff @(posedge aclk or posedge arest) begin
    if (arest)                   sat <= 1'b0;
    else if (start_acc)          sat <= 1'b0;
    else if (s1_vld && s1_clamp) sat <= 1'b1;
  end
`else
  always_comb s1_sum = s1_old + ACC_W'(s1_mag);
  assign sat = 1'b0;
`endif

  // Histogram RAM; contents are not reset, CLEAR zeroes them per frame
  always_ff @(posedge aclk) begin
    if (state == S_CLEAR) mem[clr_cnt] <= '0;
    else if (s2_vld)      mem[s2_addr] <= s2_sum;
    ram_q <= mem[s0_addr];
  end

  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en && (state == S_DONE);
      if (rd_en && (state == S_DONE) && (32'(rd_addr) < DEPTH)) rd_data <= mem[rd_addr];
      else                                                        rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_hog_cell_hist_acc.sv
// Bench for hog_cell_hist_acc on an 8x8 image, 4x4 cells, 4 bins: bench-side histogram model,
// per-cycle output compare, literal readback pins.
module tb_hog_cell_hist_acc;

  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 8;
  localparam int unsigned CELL  = 4;
  localparam int unsigned NBINS = 4;
  localparam int unsigned MAG_W = 8;
  localparam int unsigned ACC_W = 10;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned BW    = 2;
`ifdef HOG_HIST_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic             aclk = 1'b0;
  logic             arest, start, s_valid, s_last, rd_en;
  logic [BW-1:0]    s_bin;
  logic [MAG_W-1:0] s_mag;
  logic [AW-1:0]    rd_addr;
  logic             busy, s_ready, done, err, sat, rd_valid;
  logic [ACC_W-1:0] rd_data;

  hog_cell_hist_acc #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CELL(CELL), .NBINS(NBINS), .MAG_W(MAG_W), .ACC_W(ACC_W)
  ) dut (
    .aclk(aclk), .arest(arest), .start(start), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_bin(s_bin), .s_mag(s_mag), .s_last(s_last),
    .done(done), .err(err), .sat(sat),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Expected outputs, maintained by the stimulus from the timing rules
  bit mon_en = 1'b0;
  bit m_busy, m_ready, m_done, m_err, m_sat, m_sat_chk, m_rdv;
  logic [ACC_W-1:0] m_rdata;
  int hist [DEPTH];
  bit msat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge aclk) begin
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("s_ready", 32'(s_ready), 32'(m_ready));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      if (m_sat_chk) chk("sat", 32'(sat), 32'(m_sat));
      chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
      if (m_rdv) chk("rd_data", 32'(rd_data), 32'(m_rdata));
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic void model_vote(input int k, input int b, input int m);
    int col, row, a, s;
    col = k % IMG_W;
    row = k / IMG_W;
    if (b >= NBINS) return;
    a = ((row / CELL) * (IMG_W / CELL) + col / CELL) * NBINS + b;
    s = hist[a] + m;
    if (SAT_ON) begin
      if (s > 1023) begin
        s = 1023;
        msat = 1'b1;
      end
    end else begin
      s = s % 1024;
    end
    hist[a] = s;
  endfunction

  // mode 0: bin1/mag1, mode 1: bin0/mag255, mode 2: bin k%4 / mag 7k%256
  task automatic run_frame(input int mode, input int last_at, input int gap_pct,
                           input int start_at, input int rst_at);
    int n, k, b, m;
    for (int i = 0; i < DEPTH; i++) hist[i] = 0;
    msat = 1'b0;
    start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      start = 1'b0;
      if (n == 1) begin
        m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; m_sat = 1'b0; m_sat_chk = 1'b1;
      end
      if (n == 17) m_ready = 1'b1;
    end while (s_ready !== 1'b1 && n < 40);
    chk("ready_latency", 32'(n), 32'd17);
    m_sat_chk = 1'b0;
    k = 0;
    while (k < 64) begin
      if (k == rst_at) begin
        arest = 1'b1;
        s_valid = 1'b0;
        m_busy = 1'b0; m_ready = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_sat = 1'b0; m_sat_chk = 1'b1; m_rdv = 1'b0;
        tick();
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        tick();
        arest = 1'b0;
        tick();
        return;
      end
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        tick();
        continue;
      end
      b = (mode == 0) ? 1 : (mode == 1) ? 0 : k % 4;
      m = (mode == 0) ? 1 : (mode == 1) ? 255 : (k * 7) % 256;
      s_valid = 1'b1;
      s_bin   = BW'(b);
      s_mag   = MAG_W'(m);
      s_last  = (k == last_at);
      start   = (k == start_at);
      rd_en   = (k == 5);
      tick();
      s_valid = 1'b0; s_last = 1'b0; start = 1'b0; rd_en = 1'b0;
      model_vote(k, b, m);
      if ((k == last_at) != (k == 63)) m_err = 1'b1;
      if (k == last_at || k == 63) begin
        m_ready = 1'b0;
        break;
      end
      k++;
    end
    n = 0;
    do begin
      tick();
      n++;
      if (n == 2) begin
        m_done = 1'b1; m_busy = 1'b0; m_sat = msat; m_sat_chk = 1'b1;
      end
    end while (done !== 1'b1 && n < 20);
    chk("done_after_last", 32'(n + 1), 32'd3);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1;
      rd_addr = AW'(a);
      tick();
      m_rdv = 1'b1;
      m_rdata = ACC_W'(hist[a]);
    end
    rd_en = 1'b0;
    tick();
    m_rdv = 1'b0;
  endtask

  task automatic lit_read(input int a, input int v);
    rd_en = 1'b1;
    rd_addr = AW'(a);
    tick();
    m_rdv = 1'b1;
    m_rdata = ACC_W'(hist[a]);
    rd_en = 1'b0;
    chk("lit_rd_data", 32'(rd_data), 32'(v));
    tick();
    m_rdv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arest = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_bin = '0; s_mag = '0; rd_en = 1'b0; rd_addr = '0;
    tick();
    mon_en = 1'b1;
    m_sat_chk = 1'b1;
    tick();
    arest = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();

    run_frame(0, 63, 0, -1, -1);
    read_all();
    lit_read(1, 16);
    lit_read(0, 0);

    run_frame(1, 63, 0, -1, -1);
    read_all();
    lit_read(0, SAT_ON ? 1023 : 1008);
    lit_read(12, SAT_ON ? 1023 : 1008);
    chk("sat_after_fwd", 32'(sat), 32'(SAT_ON));

    run_frame(0, 63, 50, -1, -1);
    read_all();
    lit_read(13, 16);
    chk("err_gapped", 32'(err), 32'd0);

    run_frame(0, 9, 0, -1, -1);
    read_all();
    lit_read(1, 6);
    lit_read(5, 4);
    chk("err_early_last", 32'(err), 32'd1);

    run_frame(2, -1, 0, -1, -1);
    read_all();
    lit_read(2, 7 * (2 + 10 + 18 + 26));
    chk("err_missing_last", 32'(err), 32'd1);

    run_frame(0, 63, 0, -1, 30);
    run_frame(0, 63, 0, -1, -1);
    read_all();
    lit_read(5, 16);

    run_frame(0, 63, 0, 20, -1);
    read_all();
    lit_read(9, 16);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
